// File: rtl/stats_collect_flush.sv
// Statistics collector: per-channel accumulators are swept round-robin into a
// saturating memory and emitted as (tid, tdata) increments, with update and flush requests.
module stats_collect_flush #(
    parameter int COUNT          = 8,
    parameter int INC_WIDTH      = 8,
    parameter int STAT_INC_WIDTH = 16,
    parameter int STAT_ID_WIDTH  = $clog2(COUNT),
    parameter int UPDATE_PERIOD  = 1024,
    parameter int BASE_ID        = 0,
    parameter int THRESH_BIT     = STAT_INC_WIDTH - 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [INC_WIDTH*COUNT-1:0]   stat_inc,
    input  logic [COUNT-1:0]             stat_valid,
    input  logic [COUNT-1:0]             chan_enable,
    output logic [STAT_INC_WIDTH-1:0]    m_axis_stat_tdata,
    output logic [STAT_ID_WIDTH-1:0]     m_axis_stat_tid,
    output logic                         m_axis_stat_tvalid,
    input  logic                         m_axis_stat_tready,
    input  logic                         update,
    input  logic                         flush,
    output logic                         flush_busy,
    output logic                         flush_done,
    output logic [COUNT-1:0]             overflow
);

    localparam int ACC_WIDTH = INC_WIDTH + $clog2(COUNT) + 1;
    localparam int SUM_WIDTH = ((ACC_WIDTH > STAT_INC_WIDTH) ? ACC_WIDTH : STAT_INC_WIDTH) + 1;
    localparam int PTR_W     = $clog2(COUNT);
    localparam int PER_W     = (UPDATE_PERIOD > 1) ? $clog2(UPDATE_PERIOD) : 1;
    localparam logic [PER_W-1:0] PER_RELOAD = (UPDATE_PERIOD > 0) ? PER_W'(UPDATE_PERIOD - 1) : '0;

    if (COUNT > (1 << STAT_ID_WIDTH)) begin : g_id_width_check
        $error("stats_collect_flush: COUNT does not fit in STAT_ID_WIDTH");
    end
    if (THRESH_BIT < 0 || THRESH_BIT >= STAT_INC_WIDTH) begin : g_thresh_check
        $error("stats_collect_flush: THRESH_BIT out of range");
    end

    typedef enum logic {ST_READ, ST_WRITE} state_t;

    state_t                     state, state_nx;
    logic [PTR_W-1:0]           ptr;
    logic [ACC_WIDTH-1:0]       acc [COUNT];
    logic [STAT_INC_WIDTH-1:0]  mem [COUNT];
    logic [STAT_INC_WIDTH-1:0]  mem_rd_p1;
    logic [COUNT-1:0]           zero;
    logic [COUNT-1:0]           update_pend, update_pend_nx;
    logic [COUNT-1:0]           flush_pend, flush_pend_nx;
    logic [PER_W-1:0]           per_cnt;

    logic                       in_write;
    logic                       upd_evt;
    logic                       emit;
    logic [STAT_INC_WIDTH-1:0]  mem_val;
    logic [STAT_INC_WIDTH:0]    sat_res;
    logic [STAT_INC_WIDTH-1:0]  sum;
    logic [STAT_INC_WIDTH-1:0]  mem_wr;

    // Returns {overflow, clamped value} for a memory+accumulator sum.
    function automatic logic [STAT_INC_WIDTH:0] sat_sum(input logic [SUM_WIDTH-1:0] s);
        logic [SUM_WIDTH-1:0] max_v;
        max_v = SUM_WIDTH'({STAT_INC_WIDTH{1'b1}});
        if (s > max_v)
            return {1'b1, {STAT_INC_WIDTH{1'b1}}};
        return {1'b0, s[STAT_INC_WIDTH-1:0]};
    endfunction

    always_comb begin
        state_nx = (state == ST_READ) ? ST_WRITE : ST_READ;
    end

    always_comb begin
        in_write = (state == ST_WRITE);
        upd_evt  = update || ((UPDATE_PERIOD > 0) && (per_cnt == '0));
        mem_val  = zero[ptr] ? '0 : mem_rd_p1;
        sat_res  = sat_sum(SUM_WIDTH'(mem_val) + SUM_WIDTH'(acc[ptr]));
        sum      = sat_res[STAT_INC_WIDTH-1:0];
        emit     = in_write && chan_enable[ptr] && !m_axis_stat_tvalid &&
                   (update_pend[ptr] || flush_pend[ptr] || mem_val[THRESH_BIT]);
        mem_wr   = emit ? '0 : sum;

        update_pend_nx = update_pend;
        flush_pend_nx  = flush_pend;
        // A disabled channel drops its requests without emitting.
        if (in_write && (emit || !chan_enable[ptr])) begin
            update_pend_nx[ptr] = 1'b0;
            flush_pend_nx[ptr]  = 1'b0;
        end
        if (upd_evt)
            update_pend_nx = '1;
        if (flush)
            flush_pend_nx = '1;
    end

    // Memory stage: read in READ, write back in WRITE; contents are never reset.
    always_ff @(posedge clk) begin
        if (state == ST_READ)
            mem_rd_p1 <= mem[ptr];
        if (in_write)
            mem[ptr] <= mem_wr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= ST_READ;
            ptr                <= '0;
            zero               <= '1;
            update_pend        <= '0;
            flush_pend         <= '0;
            per_cnt            <= PER_RELOAD;
            overflow           <= '0;
            flush_busy         <= 1'b0;
            flush_done         <= 1'b0;
            m_axis_stat_tvalid <= 1'b0;
            m_axis_stat_tdata  <= '0;
            m_axis_stat_tid    <= '0;
            for (int n = 0; n < COUNT; n++)
                acc[n] <= '0;
        end else begin
            state       <= state_nx;
            update_pend <= update_pend_nx;
            flush_pend  <= flush_pend_nx;
            flush_done  <= 1'b0;

            if (upd_evt)
                per_cnt <= PER_RELOAD;
            else if (UPDATE_PERIOD > 0)
                per_cnt <= per_cnt - PER_W'(1);

            for (int n = 0; n < COUNT; n++) begin
                if (in_write && (ptr == PTR_W'(n)))
                    acc[n] <= (stat_valid[n] && chan_enable[n]) ?
                              ACC_WIDTH'(stat_inc[n*INC_WIDTH +: INC_WIDTH]) : '0;
                else if (stat_valid[n] && chan_enable[n])
                    acc[n] <= acc[n] + ACC_WIDTH'(stat_inc[n*INC_WIDTH +: INC_WIDTH]);
            end

            if (in_write) begin
                zero[ptr] <= 1'b0;
                if (sat_res[STAT_INC_WIDTH])
                    overflow[ptr] <= 1'b1;
                ptr <= (ptr == PTR_W'(COUNT - 1)) ? '0 : ptr + PTR_W'(1);
            end

            // Output register: one outstanding word, loaded only when idle.
            if (emit) begin
                m_axis_stat_tvalid <= (sum != '0);
                m_axis_stat_tdata  <= sum;
                m_axis_stat_tid    <= STAT_ID_WIDTH'(BASE_ID + int'(ptr));
            end else if (m_axis_stat_tvalid && m_axis_stat_tready) begin
                m_axis_stat_tvalid <= 1'b0;
            end

            if (flush)
                flush_busy <= 1'b1;
            else if (flush_busy && (flush_pend == '0) && !m_axis_stat_tvalid) begin
                flush_busy <= 1'b0;
                flush_done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_stats_collect_flush.sv
// Bench for stats_collect_flush: table-driven update vectors plus flush, threshold,
// disable, back-pressure and reset sequences, checked by a tid-keyed scoreboard.
module tb_stats_collect_flush;

    localparam int COUNT = 4;
    localparam int INC_W = 8;
    localparam int STAT_W = 8;
    localparam int ID_W = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [INC_W*COUNT-1:0]   stat_inc;
    logic [COUNT-1:0]         stat_valid;
    logic [COUNT-1:0]         chan_enable;
    logic [STAT_W-1:0]        tdata;
    logic [ID_W-1:0]          tid;
    logic                     tvalid;
    logic                     tready;
    logic                     update;
    logic                     flush;
    logic                     flush_busy;
    logic                     flush_done;
    logic [COUNT-1:0]         overflow;

    stats_collect_flush #(
        .COUNT(COUNT), .INC_WIDTH(INC_W), .STAT_INC_WIDTH(STAT_W), .STAT_ID_WIDTH(ID_W),
        .UPDATE_PERIOD(0), .BASE_ID(0), .THRESH_BIT(7)
    ) dut (
        .clk(clk), .rst(rst), .stat_inc(stat_inc), .stat_valid(stat_valid),
        .chan_enable(chan_enable), .m_axis_stat_tdata(tdata), .m_axis_stat_tid(tid),
        .m_axis_stat_tvalid(tvalid), .m_axis_stat_tready(tready), .update(update),
        .flush(flush), .flush_busy(flush_busy), .flush_done(flush_done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct { int tid; int data; } beat_t;
    typedef struct { int chan; int inc; int n; int exp_data; } vec_t;

    beat_t exp_q[$];
    vec_t  vecs[5];
    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int thresh_mode = 0;
    int thresh_beats = 0;
    int beat_sum = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic inc_chan(input int ch, input int v, input int n);
        for (int i = 0; i < n; i++) begin
            stat_inc[ch*INC_W +: INC_W] = INC_W'(v);
            stat_valid[ch] = 1'b1;
            tick();
        end
        stat_valid = '0;
    endtask

    task automatic pulse_update();
        update = 1'b1;
        tick();
        update = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int bound);
        for (int i = 0; i < bound && exp_q.size() > 0; i++)
            tick();
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic wait_done(input int bound);
        for (int i = 0; i < bound && done_cnt == 0; i++)
            @(negedge clk);
    endtask

    task automatic wait_tvalid(input int bound);
        for (int i = 0; i < bound && tvalid !== 1'b1; i++)
            @(negedge clk);
    endtask

    // Output monitor: samples on the falling edge, one handshake per accepted beat.
    always @(negedge clk) begin
        int idx;
        if (!rst) begin
            if (flush_done)
                done_cnt++;
            if (tvalid && tready) begin
                beat_sum += int'(tdata);
                if (thresh_mode != 0) begin
                    thresh_beats++;
                    check("thresh_beat_tid", int'(tid), 1);
                    check("thresh_beat_data", int'(tdata), 255);
                end else begin
                    idx = -1;
                    for (int i = 0; i < exp_q.size(); i++)
                        if (exp_q[i].tid == int'(tid) && idx < 0)
                            idx = i;
                    if (idx < 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got tid=%0d tdata=%0d, expected no beat", tid, tdata);
                    end else begin
                        check("beat_data", int'(tdata), exp_q[idx].data);
                        exp_q.delete(idx);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, t0, stable_err;
        vecs[0] = '{2, 5, 10, 50};
        vecs[1] = '{0, 3, 1, 3};
        vecs[2] = '{3, 7, 2, 14};
        vecs[3] = '{1, 1, 20, 20};
        vecs[4] = '{0, 12, 9, 108};

        rst = 1'b1;
        stat_inc = '0;
        stat_valid = '0;
        chan_enable = '1;
        tready = 1'b1;
        update = 1'b0;
        flush = 1'b0;
        tick();
        tick();
        check("rst_tvalid", int'(tvalid), 0);
        check("rst_tdata", int'(tdata), 0);
        check("rst_tid", int'(tid), 0);
        check("rst_flush_busy", int'(flush_busy), 0);
        check("rst_flush_done", int'(flush_done), 0);
        check("rst_overflow", int'(overflow), 0);
        rst = 1'b0;
        tick();

        // Single-channel accumulate then update: exactly one beat per vector.
        for (int v = 0; v < 5; v++) begin
            inc_chan(vecs[v].chan, vecs[v].inc, vecs[v].n);
            pulse_update();
            exp_q.push_back('{vecs[v].chan, vecs[v].exp_data});
            wait_drain("update_vec_drain", 40);
            repeat (20) tick();
        end

        // Flush with two active channels.
        stat_inc[0 +: 8] = 8'd3;
        stat_inc[24 +: 8] = 8'd7;
        stat_valid = 4'b1001;
        tick();
        stat_valid = '0;
        done_cnt = 0;
        exp_q.push_back('{0, 3});
        exp_q.push_back('{3, 7});
        pulse_flush();
        @(negedge clk);
        check("flush_busy_set", int'(flush_busy), 1);
        wait_done(2*COUNT + 6);
        check("flush_done_seen", done_cnt, 1);
        check("flush_beats_before_done", exp_q.size(), 0);
        check("flush_busy_clear", int'(flush_busy), 0);
        exp_q.delete();
        repeat (10) tick();
        check("flush_done_once", done_cnt, 1);

        // Threshold early emission with saturation on ch1, no update requests.
        thresh_mode = 1;
        thresh_beats = 0;
        inc_chan(1, 255, 40);
        repeat (40) tick();
        thresh_mode = 0;
        check("thresh_has_beats", int'(thresh_beats > 0), 1);
        check("overflow_ch1", int'(overflow), 4'b0010);

        // Disabled channel produces no beat; flush still completes.
        chan_enable = 4'b1101;
        stat_inc[8 +: 8] = 8'd9;
        stat_inc[16 +: 8] = 8'd4;
        stat_valid = 4'b0110;
        tick();
        stat_valid = '0;
        inc_chan(1, 9, 4);
        done_cnt = 0;
        exp_q.push_back('{2, 4});
        pulse_flush();
        wait_done(2*COUNT + 6);
        check("dis_flush_done", done_cnt, 1);
        check("dis_beats", exp_q.size(), 0);
        exp_q.delete();
        chan_enable = '1;
        pulse_update();
        repeat (20) tick();

        // Back-pressure during flush: held word stable, totals preserved.
        tready = 1'b0;
        inc_chan(0, 10, 3);
        inc_chan(2, 6, 2);
        inc_chan(3, 1, 5);
        beat_sum = 0;
        done_cnt = 0;
        exp_q.push_back('{0, 30});
        exp_q.push_back('{2, 12});
        exp_q.push_back('{3, 5});
        pulse_flush();
        wait_tvalid(20);
        check("stall_tvalid_rise", int'(tvalid), 1);
        d0 = int'(tdata);
        t0 = int'(tid);
        stable_err = 0;
        repeat (100) begin
            @(negedge clk);
            if (tvalid !== 1'b1 || int'(tdata) != d0 || int'(tid) != t0)
                stable_err++;
        end
        check("stall_hold_stable", stable_err, 0);
        check("stall_no_done", done_cnt, 0);
        tready = 1'b1;
        wait_done(40);
        check("stall_flush_done", done_cnt, 1);
        check("stall_beats", exp_q.size(), 0);
        check("stall_sum", beat_sum, 47);
        exp_q.delete();
        repeat (10) tick();

        // Reset in the middle of a stalled flush.
        tready = 1'b0;
        inc_chan(2, 20, 1);
        done_cnt = 0;
        pulse_flush();
        wait_tvalid(20);
        check("mid_rst_pre_tvalid", int'(tvalid), 1);
        check("mid_rst_pre_busy", int'(flush_busy), 1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_tvalid", int'(tvalid), 0);
        check("mid_rst_busy", int'(flush_busy), 0);
        check("mid_rst_overflow", int'(overflow), 0);
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (30) tick();
        tready = 1'b1;
        inc_chan(0, 4, 1);
        pulse_update();
        exp_q.push_back('{0, 4});
        wait_drain("post_rst_update", 40);
        repeat (20) tick();
        check("post_rst_no_done", done_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stats_collect_flush.md
Name: stats_collect_flush

Overview:
Parametrised successor statistics collector. COUNT increment channels feed small per-channel accumulators. These are swept round-robin into a STAT_INC_WIDTH-wide per-channel memory and emitted as (tid, tdata) increments on an AXI-stream-style output toward the stats counter block. Additions over the previous generation:
- per-channel enable mask
- explicit flush with completion pulse
- configurable early-flush threshold
- saturating accumulation with sticky overflow flags
- optional disable of the periodic update

Parameters:
COUNT, 8, channel count (>=2)
INC_WIDTH, 8, per-channel increment width
STAT_INC_WIDTH, 16, output increment width / memory word width
STAT_ID_WIDTH, $clog2(COUNT), output ID width; COUNT > 2**STAT_ID_WIDTH is an elaboration error
UPDATE_PERIOD, 1024, cycles between automatic updates; 0 disables the periodic update
BASE_ID, 0, tid of channel 0
THRESH_BIT, STAT_INC_WIDTH-1, memory bit that forces early emission when set (0..STAT_INC_WIDTH-1)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
stat_inc  in  INC_WIDTH*COUNT  per-channel increment values
stat_valid  in  COUNT  per-channel increment strobes
chan_enable  in  COUNT  per-channel enable
m_axis_stat_tdata  out  STAT_INC_WIDTH  increment value
m_axis_stat_tid  out  STAT_ID_WIDTH  counter ID
m_axis_stat_tvalid  out  1  output valid
m_axis_stat_tready  in  1  output ready
update  in  1  request update of all channels
flush  in  1  request flush of all channels with completion indication
flush_busy  out  1  flush in progress
flush_done  out  1  one-cycle pulse on flush completion
overflow  out  COUNT  sticky per-channel saturation flags

Behaviour:
Reset:
- Single clock domain. rst asynchronously clears all control registers.
- Reset values: tvalid=0, tdata=0, tid=0, flush_busy=0, flush_done=0, overflow=0.
- Also cleared: sweep pointer=0, state=READ, accumulators=0, update_pend=0, flush_pend=0, period counter=UPDATE_PERIOD-1.
- zero flags are all set, marking memory words invalid (read as 0). Memory itself is not reset.

Accumulators:
- ACC_WIDTH = INC_WIDTH+$clog2(COUNT)+1. One accumulator per channel.
- acc += stat_inc[n] when stat_valid[n] && chan_enable[n].
- On clear in the same cycle as a valid increment, acc loads that increment.

Sweep:
- Two-state FSM: READ -> WRITE -> READ. READ reads mem[ptr].
- WRITE processes channel ptr, then advances ptr (COUNT-1 wraps to 0). Each channel is visited every 2*COUNT cycles.
- In WRITE: sum = (zero[ptr] ? 0 : mem) + acc, saturated to 2**STAT_INC_WIDTH-1.
- If saturation occurs, overflow[ptr] is set. It stays set until rst.
- acc[ptr] is cleared and zero[ptr] is cleared.

Emit condition:
- Emit when chan_enable[ptr] && !tvalid && (update_pend[ptr] || flush_pend[ptr] || mem[THRESH_BIT]).
- On emit: mem <= 0; tdata <= sum; tid <= ptr+BASE_ID; tvalid <= (sum != 0).
- On emit, update_pend[ptr] and flush_pend[ptr] are cleared.
- Otherwise: mem <= sum; pending bits are kept.

Disabled channel in WRITE:
- The accumulator is still cleared and the memory is kept (mem <= sum).
- flush_pend[ptr] and update_pend[ptr] are cleared without emitting.

Output handshake:
- tvalid is held with tdata/tid stable until tvalid && tready. tvalid drops the following cycle.
- A new word may load only when tvalid=0. There is at most one outstanding word.

Update:
- Sets update_pend to all ones when update=1, or when the period counter is 0 (UPDATE_PERIOD>0 only).
- The period counter reloads UPDATE_PERIOD-1 on either event and otherwise decrements.

Flush:
- flush=1 sets flush_pend to all ones and flush_busy=1. A flush during a busy flush re-arms all bits.
- When flush_busy && flush_pend==0 && !tvalid: flush_done pulses for 1 cycle and flush_busy clears.
- Worst-case flush latency with tready=1 is 2*COUNT+3 cycles.
- Simultaneous flush and update: both pending vectors are set. This is harmless.

Reset mid-operation:
- An outstanding tvalid is dropped and the pending flush is abandoned. flush_done does not pulse.

Test Plan:
- COUNT=4: all channels enabled, tready=1, stat_valid[2]=1 with inc=5 for 10 cycles, then update -> exactly one beat tid=2 tdata=50. No beats for idle channels.
- flush after inc 3 on ch0 and 7 on ch3 -> beats (0,3) then (3,7). flush_done pulses once after the last beat is accepted. flush_busy is high in between.
- STAT_INC_WIDTH=8, THRESH_BIT=7, UPDATE_PERIOD=0, ch1 inc 255 every cycle -> early beats with tid=1 once mem>=128, no update needed. overflow[1] is set once the sum saturates at 255.
- chan_enable[1]=0 while ch1 strobes inc=9, then flush -> no tid=1 beat. flush still completes.
- tready=0 for 100 cycles during flush -> tvalid/tdata/tid stay stable. No increments are lost: the sum of emitted tdata after tready=1 equals the total injected.
- Assert rst mid-flush with tvalid=1 -> tvalid, flush_busy and overflow go 0 immediately (async). No flush_done pulse. The first post-reset update emits only post-reset increments.
